// File: rtl/experiment_sequencer.sv
// rtl/experiment_sequencer.sv - multi-shot scheduler in front of fsm_experiment
// Per-shot arm/fire/wait/cooldown with timeout, abort and forced-reset recovery.
module experiment_sequencer #(
    parameter int SHOT_W      = 8,
    parameter int CNT_W       = 32,
    parameter int RECOVER_LEN = 16
) (
    input  logic              clock,
    input  logic              reset_signal,
    input  logic              cmd_run,
    input  logic              cmd_abort,
    input  logic [SHOT_W-1:0] cfg_n_shots,
    input  logic [CNT_W-1:0]  cfg_ready_timeout,
    input  logic [CNT_W-1:0]  cfg_shot_timeout,
    input  logic [CNT_W-1:0]  cfg_cooldown,
    input  logic              detector_ready,
    input  logic              exp_done,
    input  logic              exp_error,
    output logic              exp_start,
    output logic              exp_reset_n,
    output logic              busy,
    output logic [SHOT_W-1:0] shot_index,
    output logic [SHOT_W-1:0] shots_ok,
    output logic [SHOT_W-1:0] shots_failed,
    output logic              seq_done,
    output logic              seq_aborted,
    output logic [7:0]        seq_state
);
    typedef enum logic [7:0] {
        S_IDLE     = 8'h00,
        S_ARM      = 8'h01,
        S_FIRE     = 8'h02,
        S_WAIT     = 8'h03,
        S_COOLDOWN = 8'h04,
        S_RECOVER  = 8'h05,
        S_DONE     = 8'h06,
        S_ABORT    = 8'h07
    } state_t;

    localparam logic [SHOT_W-1:0] SHOT_ONE = SHOT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  REC_LAST = CNT_W'(RECOVER_LEN - 1);

    state_t            r_state;
    logic [SHOT_W-1:0] r_n_shots;
    logic [SHOT_W-1:0] r_shot_index;
    logic [SHOT_W-1:0] r_shots_ok;
    logic [SHOT_W-1:0] r_shots_failed;
    logic [CNT_W-1:0]  r_ready_to;
    logic [CNT_W-1:0]  r_shot_to;
    logic [CNT_W-1:0]  r_cooldown;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_exp_start;
    logic              r_exp_reset_n;
    logic              r_busy;
    logic              r_seq_done;
    logic              r_seq_aborted;
    logic              r_aborted;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_abort;
    logic              w_ready_expired;
    logic              w_shot_expired;
    logic              w_cool_end;
    logic              w_rec_end;
    logic              w_last_shot;

    // One shared counter serves every timed state; it is cleared on each state entry.
    assign w_cnt_inc       = r_cnt + CNT_ONE;
    assign w_abort         = cmd_abort &&
                             (r_state inside {S_ARM, S_FIRE, S_WAIT, S_COOLDOWN, S_RECOVER});
    assign w_ready_expired = (r_ready_to != '0) && (w_cnt_inc >= r_ready_to);
    assign w_shot_expired  = (r_shot_to != '0) && (w_cnt_inc >= r_shot_to);
    assign w_cool_end      = (w_cnt_inc >= r_cooldown);
    assign w_rec_end       = (r_cnt == REC_LAST);
    assign w_last_shot     = (r_shot_index == (r_n_shots - SHOT_ONE));

    function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] v);
        return (&v) ? v : (v + SHOT_ONE);
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            r_state        <= S_IDLE;
            r_n_shots      <= '0;
            r_shot_index   <= '0;
            r_shots_ok     <= '0;
            r_shots_failed <= '0;
            r_ready_to     <= '0;
            r_shot_to      <= '0;
            r_cooldown     <= '0;
            r_cnt          <= '0;
            r_exp_start    <= 1'b0;
            r_exp_reset_n  <= 1'b0;
            r_busy         <= 1'b0;
            r_seq_done     <= 1'b0;
            r_seq_aborted  <= 1'b0;
            r_aborted      <= 1'b0;
        end else begin
            r_exp_start   <= 1'b0;
            r_seq_done    <= 1'b0;
            r_seq_aborted <= 1'b0;
            if (w_abort) begin
                r_state       <= S_ABORT;
                r_cnt         <= '0;
                r_exp_reset_n <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_exp_reset_n <= 1'b1;
                        if (cmd_run) begin
                            r_n_shots      <= cfg_n_shots;
                            r_ready_to     <= cfg_ready_timeout;
                            r_shot_to      <= cfg_shot_timeout;
                            r_cooldown     <= cfg_cooldown;
                            r_shot_index   <= '0;
                            r_shots_ok     <= '0;
                            r_shots_failed <= '0;
                            r_cnt          <= '0;
                            r_aborted      <= 1'b0;
                            r_busy         <= 1'b1;
                            r_state        <= (cfg_n_shots == '0) ? S_DONE : S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (detector_ready) begin
                            r_state     <= S_FIRE;
                            r_exp_start <= 1'b1;
                        end else if (w_ready_expired) begin
                            r_shots_failed <= sat_inc(r_shots_failed);
                            r_state        <= S_RECOVER;
                            r_cnt          <= '0;
                            r_exp_reset_n  <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_FIRE: begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Error outranks done, and either event outranks a coincident timeout.
                        if (exp_error || (!exp_done && w_shot_expired)) begin
                            r_shots_failed <= sat_inc(r_shots_failed);
                            r_state        <= S_RECOVER;
                            r_cnt          <= '0;
                            r_exp_reset_n  <= 1'b0;
                        end else if (exp_done) begin
                            r_shots_ok <= sat_inc(r_shots_ok);
                            r_state    <= S_COOLDOWN;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_RECOVER: begin
                        if (w_rec_end) begin
                            r_exp_reset_n <= 1'b1;
                            r_state       <= S_COOLDOWN;
                            r_cnt         <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_COOLDOWN: begin
                        if (w_cool_end) begin
                            r_cnt <= '0;
                            if (w_last_shot) begin
                                r_state <= S_DONE;
                            end else begin
                                r_shot_index <= r_shot_index + SHOT_ONE;
                                r_state      <= S_ARM;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_DONE: begin
                        r_seq_done    <= 1'b1;
                        r_seq_aborted <= r_aborted;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                    S_ABORT: begin
                        if (w_rec_end) begin
                            r_exp_reset_n <= 1'b1;
                            r_aborted     <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign exp_start    = r_exp_start;
    assign exp_reset_n  = r_exp_reset_n;
    assign busy         = r_busy;
    assign shot_index   = r_shot_index;
    assign shots_ok     = r_shots_ok;
    assign shots_failed = r_shots_failed;
    assign seq_done     = r_seq_done;
    assign seq_aborted  = r_seq_aborted;
    assign seq_state    = r_state;

endmodule

// File: tb/tb_experiment_sequencer.sv
// tb/tb_experiment_sequencer.sv - scoreboard bench for experiment_sequencer
`timescale 1ns/1ps
module tb_experiment_sequencer;
    localparam int SHOT_W = 8;
    localparam int CNT_W  = 32;
    localparam int REC    = 16;

    logic              clock = 1'b0;
    logic              reset_signal = 1'b0;
    logic              cmd_run = 1'b0;
    logic              cmd_abort = 1'b0;
    logic [SHOT_W-1:0] cfg_n_shots = '0;
    logic [CNT_W-1:0]  cfg_ready_timeout = '0;
    logic [CNT_W-1:0]  cfg_shot_timeout = '0;
    logic [CNT_W-1:0]  cfg_cooldown = '0;
    logic              detector_ready = 1'b1;
    logic              exp_done = 1'b0;
    logic              exp_error = 1'b0;
    logic              exp_start;
    logic              exp_reset_n;
    logic              busy;
    logic [SHOT_W-1:0] shot_index;
    logic [SHOT_W-1:0] shots_ok;
    logic [SHOT_W-1:0] shots_failed;
    logic              seq_done;
    logic              seq_aborted;
    logic [7:0]        seq_state;

    experiment_sequencer #(.SHOT_W(SHOT_W), .CNT_W(CNT_W), .RECOVER_LEN(REC)) dut (
        .clock(clock), .reset_signal(reset_signal), .cmd_run(cmd_run), .cmd_abort(cmd_abort),
        .cfg_n_shots(cfg_n_shots), .cfg_ready_timeout(cfg_ready_timeout),
        .cfg_shot_timeout(cfg_shot_timeout), .cfg_cooldown(cfg_cooldown),
        .detector_ready(detector_ready), .exp_done(exp_done), .exp_error(exp_error),
        .exp_start(exp_start), .exp_reset_n(exp_reset_n), .busy(busy),
        .shot_index(shot_index), .shots_ok(shots_ok), .shots_failed(shots_failed),
        .seq_done(seq_done), .seq_aborted(seq_aborted), .seq_state(seq_state)
    );

    always #2.5 clock = ~clock;

    typedef struct packed {int cyc; int ok; int failed; int aborted;} done_t;
    typedef struct packed {int start; int len;} rec_t;

    int    exp_start_q[$];
    int    obs_start_q[$];
    done_t exp_done_q[$];
    done_t obs_done_q[$];
    rec_t  exp_rec_q[$];
    rec_t  obs_rec_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int pend = -1;
    int rec_start = -1;
    int resp_delay = 20;
    bit prev_rn = 1'b0;
    bit resp_en = 1'b1;
    bit resp_err = 1'b0;

    // Advance one cycle, log DUT events, and play the fsm_experiment responder.
    task automatic step();
        done_t d;
        rec_t  r;
        @(posedge clock);
        #1;
        cyc++;
        if (exp_start === 1'b1) begin
            obs_start_q.push_back(cyc);
            if (resp_en) pend = cyc + resp_delay;
        end
        if (seq_done === 1'b1) begin
            d.cyc = cyc; d.ok = int'(shots_ok); d.failed = int'(shots_failed);
            d.aborted = int'(seq_aborted);
            obs_done_q.push_back(d);
        end
        if (reset_signal) begin
            if (!exp_reset_n && prev_rn) rec_start = cyc;
            if (exp_reset_n && !prev_rn && rec_start >= 0) begin
                r.start = rec_start; r.len = cyc - rec_start;
                obs_rec_q.push_back(r);
                rec_start = -1;
            end
        end
        prev_rn   = exp_reset_n;
        exp_done  = (pend == cyc);
        exp_error = (pend == cyc) && resp_err;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic start_run(input int n, input int rto, input int sto, input int cool,
                             output int n_cyc);
        cfg_n_shots = SHOT_W'(n);
        cfg_ready_timeout = CNT_W'(rto);
        cfg_shot_timeout = CNT_W'(sto);
        cfg_cooldown = CNT_W'(cool);
        n_cyc = cyc;
        cmd_run = 1'b1;
        step();
        cmd_run = 1'b0;
    endtask

    task automatic push_done(input int c, input int ok, input int failed, input int ab);
        done_t d;
        d.cyc = c; d.ok = ok; d.failed = failed; d.aborted = ab;
        exp_done_q.push_back(d);
    endtask

    task automatic push_rec(input int s);
        rec_t r;
        r.start = s; r.len = REC;
        exp_rec_q.push_back(r);
    endtask

    task automatic test_reset();
        reset_signal = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (exp_reset_n !== 1'b0) begin
            n_err++; $display("FAIL reset_exp_reset_n: got %b, expected 0", exp_reset_n);
        end
        n_cmp++;
        if ({exp_start, busy, seq_done, seq_aborted} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, expected 0000", {exp_start, busy, seq_done, seq_aborted});
        end
        n_cmp++;
        if ({shot_index, shots_ok, shots_failed, seq_state} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_counters: got %h, expected 0", {shot_index, shots_ok, shots_failed, seq_state});
        end
        reset_signal = 1'b1;
        step();
        n_cmp++;
        if (exp_reset_n !== 1'b1) begin
            n_err++; $display("FAIL reset_release_exp_reset_n: got %b, expected 1", exp_reset_n);
        end
    endtask

    task automatic test_multi_shot();
        int n, e, o;
        done_t de, dobs;
        rec_t re, ro;
        detector_ready = 1'b1; resp_en = 1'b1; resp_err = 1'b0; resp_delay = 20;
        start_run(3, 0, 0, 10, n);
        for (int k = 0; k < 3; k++) exp_start_q.push_back(n + 2 + 32 * k);
        push_done(n + 98, 3, 0, 0);
        run_until(n + 120);
        while (exp_start_q.size() > 0 || obs_start_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_start_q.size() > 0) e = exp_start_q.pop_front();
            if (obs_start_q.size() > 0) o = obs_start_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL multi_shot_start: got cycle %0d, expected %0d", o, e); end
        end
        while (exp_done_q.size() > 0 || obs_done_q.size() > 0) begin
            de = '{-1, -1, -1, -1}; dobs = '{-1, -1, -1, -1};
            if (exp_done_q.size() > 0) de = exp_done_q.pop_front();
            if (obs_done_q.size() > 0) dobs = obs_done_q.pop_front();
            n_cmp++;
            if (dobs !== de) begin
                n_err++;
                $display("FAIL multi_shot_done: got cyc=%0d ok=%0d fail=%0d ab=%0d, expected cyc=%0d ok=%0d fail=%0d ab=%0d",
                         dobs.cyc, dobs.ok, dobs.failed, dobs.aborted, de.cyc, de.ok, de.failed, de.aborted);
            end
        end
        while (exp_rec_q.size() > 0 || obs_rec_q.size() > 0) begin
            re = '{-1, -1}; ro = '{-1, -1};
            if (exp_rec_q.size() > 0) re = exp_rec_q.pop_front();
            if (obs_rec_q.size() > 0) ro = obs_rec_q.pop_front();
            n_cmp++;
            if (ro !== re) begin
                n_err++; $display("FAIL multi_shot_recover: got %0d/%0d, expected %0d/%0d", ro.start, ro.len, re.start, re.len);
            end
        end
        n_cmp++;
        if ({busy, shots_ok} !== {1'b0, 8'd3}) begin
            n_err++; $display("FAIL multi_shot_hold: got busy=%b ok=%0d, expected busy=0 ok=3", busy, shots_ok);
        end
    endtask

    task automatic test_shot_timeout();
        int n, s1, s2, e, o;
        done_t de, dobs;
        rec_t re, ro;
        resp_en = 1'b0;
        start_run(2, 0, 100, 0, n);
        s1 = n + 2;
        s2 = s1 + 119;
        exp_start_q.push_back(s1); exp_start_q.push_back(s2);
        push_rec(s1 + 101); push_rec(s2 + 101);
        push_done(s2 + 119, 0, 2, 0);
        run_until(s1 + 118);
        n_cmp++;
        if ({shots_failed, shot_index} !== {8'd1, 8'd1}) begin
            n_err++; $display("FAIL shot_timeout_continue: got fail=%0d idx=%0d, expected fail=1 idx=1", shots_failed, shot_index);
        end
        run_until(s2 + 130);
        while (exp_start_q.size() > 0 || obs_start_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_start_q.size() > 0) e = exp_start_q.pop_front();
            if (obs_start_q.size() > 0) o = obs_start_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL shot_timeout_start: got cycle %0d, expected %0d", o, e); end
        end
        while (exp_done_q.size() > 0 || obs_done_q.size() > 0) begin
            de = '{-1, -1, -1, -1}; dobs = '{-1, -1, -1, -1};
            if (exp_done_q.size() > 0) de = exp_done_q.pop_front();
            if (obs_done_q.size() > 0) dobs = obs_done_q.pop_front();
            n_cmp++;
            if (dobs !== de) begin
                n_err++;
                $display("FAIL shot_timeout_done: got cyc=%0d ok=%0d fail=%0d ab=%0d, expected cyc=%0d ok=%0d fail=%0d ab=%0d",
                         dobs.cyc, dobs.ok, dobs.failed, dobs.aborted, de.cyc, de.ok, de.failed, de.aborted);
            end
        end
        while (exp_rec_q.size() > 0 || obs_rec_q.size() > 0) begin
            re = '{-1, -1}; ro = '{-1, -1};
            if (exp_rec_q.size() > 0) re = exp_rec_q.pop_front();
            if (obs_rec_q.size() > 0) ro = obs_rec_q.pop_front();
            n_cmp++;
            if (ro !== re) begin
                n_err++; $display("FAIL shot_timeout_recover: got %0d/%0d, expected %0d/%0d", ro.start, ro.len, re.start, re.len);
            end
        end
        resp_en = 1'b1;
    endtask

    task automatic test_ready_timeout();
        int n, e, o;
        done_t de, dobs;
        rec_t re, ro;
        detector_ready = 1'b0;
        start_run(1, 50, 0, 0, n);
        push_rec(n + 51);
        push_done(n + 69, 0, 1, 0);
        run_until(n + 80);
        detector_ready = 1'b1;
        while (exp_start_q.size() > 0 || obs_start_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_start_q.size() > 0) e = exp_start_q.pop_front();
            if (obs_start_q.size() > 0) o = obs_start_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL ready_timeout_start: got cycle %0d, expected %0d", o, e); end
        end
        while (exp_done_q.size() > 0 || obs_done_q.size() > 0) begin
            de = '{-1, -1, -1, -1}; dobs = '{-1, -1, -1, -1};
            if (exp_done_q.size() > 0) de = exp_done_q.pop_front();
            if (obs_done_q.size() > 0) dobs = obs_done_q.pop_front();
            n_cmp++;
            if (dobs !== de) begin
                n_err++;
                $display("FAIL ready_timeout_done: got cyc=%0d ok=%0d fail=%0d ab=%0d, expected cyc=%0d ok=%0d fail=%0d ab=%0d",
                         dobs.cyc, dobs.ok, dobs.failed, dobs.aborted, de.cyc, de.ok, de.failed, de.aborted);
            end
        end
        while (exp_rec_q.size() > 0 || obs_rec_q.size() > 0) begin
            re = '{-1, -1}; ro = '{-1, -1};
            if (exp_rec_q.size() > 0) re = exp_rec_q.pop_front();
            if (obs_rec_q.size() > 0) ro = obs_rec_q.pop_front();
            n_cmp++;
            if (ro !== re) begin
                n_err++; $display("FAIL ready_timeout_recover: got %0d/%0d, expected %0d/%0d", ro.start, ro.len, re.start, re.len);
            end
        end
    endtask

    task automatic test_done_and_error();
        int n, s, e, o;
        done_t de, dobs;
        rec_t re, ro;
        resp_en = 1'b1; resp_err = 1'b1; resp_delay = 20;
        start_run(1, 0, 0, 0, n);
        s = n + 2;
        exp_start_q.push_back(s);
        push_rec(s + 21);
        push_done(s + 39, 0, 1, 0);
        run_until(s + 45);
        resp_err = 1'b0;
        while (exp_start_q.size() > 0 || obs_start_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_start_q.size() > 0) e = exp_start_q.pop_front();
            if (obs_start_q.size() > 0) o = obs_start_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL done_error_start: got cycle %0d, expected %0d", o, e); end
        end
        while (exp_done_q.size() > 0 || obs_done_q.size() > 0) begin
            de = '{-1, -1, -1, -1}; dobs = '{-1, -1, -1, -1};
            if (exp_done_q.size() > 0) de = exp_done_q.pop_front();
            if (obs_done_q.size() > 0) dobs = obs_done_q.pop_front();
            n_cmp++;
            if (dobs !== de) begin
                n_err++;
                $display("FAIL done_error_done: got cyc=%0d ok=%0d fail=%0d ab=%0d, expected cyc=%0d ok=%0d fail=%0d ab=%0d",
                         dobs.cyc, dobs.ok, dobs.failed, dobs.aborted, de.cyc, de.ok, de.failed, de.aborted);
            end
        end
        while (exp_rec_q.size() > 0 || obs_rec_q.size() > 0) begin
            re = '{-1, -1}; ro = '{-1, -1};
            if (exp_rec_q.size() > 0) re = exp_rec_q.pop_front();
            if (obs_rec_q.size() > 0) ro = obs_rec_q.pop_front();
            n_cmp++;
            if (ro !== re) begin
                n_err++; $display("FAIL done_error_recover: got %0d/%0d, expected %0d/%0d", ro.start, ro.len, re.start, re.len);
            end
        end
        exp_done = 1'b1; exp_error = 1'b1;
        step();
        step();
        n_cmp++;
        if ({shots_ok, shots_failed, busy} !== {8'd0, 8'd1, 1'b0}) begin
            n_err++;
            $display("FAIL idle_events_ignored: got ok=%0d fail=%0d busy=%b, expected ok=0 fail=1 busy=0", shots_ok, shots_failed, busy);
        end
    endtask

    task automatic test_abort();
        int n, s1, s2, a, e, o;
        done_t de, dobs;
        rec_t re, ro;
        resp_en = 1'b1; resp_err = 1'b0; resp_delay = 20;
        start_run(5, 0, 0, 10, n);
        s1 = n + 2;
        s2 = n + 34;
        run_until(n + 10);
        cfg_n_shots = 8'd9;
        cmd_run = 1'b1;
        step();
        cmd_run = 1'b0;
        a = s2 + 5;
        run_until(a);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        exp_start_q.push_back(s1); exp_start_q.push_back(s2);
        push_rec(a + 1);
        push_done(a + 18, 1, 0, 1);
        run_until(a + 30);
        while (exp_start_q.size() > 0 || obs_start_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_start_q.size() > 0) e = exp_start_q.pop_front();
            if (obs_start_q.size() > 0) o = obs_start_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL abort_start: got cycle %0d, expected %0d", o, e); end
        end
        while (exp_done_q.size() > 0 || obs_done_q.size() > 0) begin
            de = '{-1, -1, -1, -1}; dobs = '{-1, -1, -1, -1};
            if (exp_done_q.size() > 0) de = exp_done_q.pop_front();
            if (obs_done_q.size() > 0) dobs = obs_done_q.pop_front();
            n_cmp++;
            if (dobs !== de) begin
                n_err++;
                $display("FAIL abort_done: got cyc=%0d ok=%0d fail=%0d ab=%0d, expected cyc=%0d ok=%0d fail=%0d ab=%0d",
                         dobs.cyc, dobs.ok, dobs.failed, dobs.aborted, de.cyc, de.ok, de.failed, de.aborted);
            end
        end
        while (exp_rec_q.size() > 0 || obs_rec_q.size() > 0) begin
            re = '{-1, -1}; ro = '{-1, -1};
            if (exp_rec_q.size() > 0) re = exp_rec_q.pop_front();
            if (obs_rec_q.size() > 0) ro = obs_rec_q.pop_front();
            n_cmp++;
            if (ro !== re) begin
                n_err++; $display("FAIL abort_recover: got %0d/%0d, expected %0d/%0d", ro.start, ro.len, re.start, re.len);
            end
        end
        n_cmp++;
        if ({busy, seq_state} !== {1'b0, 8'h00}) begin
            n_err++; $display("FAIL abort_idle: got busy=%b state=%h, expected busy=0 state=00", busy, seq_state);
        end
    endtask

    task automatic test_zero_shots_and_reset();
        int n, s1, e, o;
        done_t de, dobs;
        rec_t re, ro;
        start_run(0, 0, 0, 0, n);
        push_done(n + 2, 0, 0, 0);
        run_until(n + 6);
        start_run(2, 0, 0, 50, n);
        s1 = n + 2;
        exp_start_q.push_back(s1);
        run_until(s1 + 25);
        n_cmp++;
        if (seq_state !== 8'h04) begin
            n_err++; $display("FAIL reset_mid_run_precond: got state %h, expected 04", seq_state);
        end
        reset_signal = 1'b0;
        step();
        n_cmp++;
        if ({exp_start, exp_reset_n, busy, seq_done, seq_aborted} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_mid_run_flags: got %b, expected 00000", {exp_start, exp_reset_n, busy, seq_done, seq_aborted});
        end
        n_cmp++;
        if ({shot_index, shots_ok, shots_failed, seq_state} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_run_counters: got %h, expected 0", {shot_index, shots_ok, shots_failed, seq_state});
        end
        reset_signal = 1'b1;
        step();
        n_cmp++;
        if (exp_reset_n !== 1'b1) begin
            n_err++; $display("FAIL reset_mid_run_release: got %b, expected 1", exp_reset_n);
        end
        run_until(s1 + 80);
        while (exp_start_q.size() > 0 || obs_start_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_start_q.size() > 0) e = exp_start_q.pop_front();
            if (obs_start_q.size() > 0) o = obs_start_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL zero_reset_start: got cycle %0d, expected %0d", o, e); end
        end
        while (exp_done_q.size() > 0 || obs_done_q.size() > 0) begin
            de = '{-1, -1, -1, -1}; dobs = '{-1, -1, -1, -1};
            if (exp_done_q.size() > 0) de = exp_done_q.pop_front();
            if (obs_done_q.size() > 0) dobs = obs_done_q.pop_front();
            n_cmp++;
            if (dobs !== de) begin
                n_err++;
                $display("FAIL zero_reset_done: got cyc=%0d ok=%0d fail=%0d ab=%0d, expected cyc=%0d ok=%0d fail=%0d ab=%0d",
                         dobs.cyc, dobs.ok, dobs.failed, dobs.aborted, de.cyc, de.ok, de.failed, de.aborted);
            end
        end
        while (exp_rec_q.size() > 0 || obs_rec_q.size() > 0) begin
            re = '{-1, -1}; ro = '{-1, -1};
            if (exp_rec_q.size() > 0) re = exp_rec_q.pop_front();
            if (obs_rec_q.size() > 0) ro = obs_rec_q.pop_front();
            n_cmp++;
            if (ro !== re) begin
                n_err++; $display("FAIL zero_reset_recover: got %0d/%0d, expected %0d/%0d", ro.start, ro.len, re.start, re.len);
            end
        end
    endtask

    initial begin
        test_reset();
        repeat (2) step();
        test_multi_shot();
        repeat (2) step();
        test_shot_timeout();
        repeat (2) step();
        test_ready_timeout();
        repeat (2) step();
        test_done_and_error();
        repeat (2) step();
        test_abort();
        repeat (2) step();
        test_zero_shots_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
